// File: rtl/rom_prefetch_fifo.sv
// Prefetches a contiguous run of ROM words into a small FWFT FIFO.
// One flash read in flight at a time; a read is issued only when the FIFO has room.
module rom_prefetch_fifo #(
    parameter int WIDTH      = 8,
    parameter int ADDR_W     = 24,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [15:0]           length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     rom_addr,
    output logic                  rom_load,
    input  logic [WIDTH-1:0]      rom_data,
    input  logic                  rom_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_pop,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, GUARD, WAIT} state_t;

    state_t                state, state_nxt;
    logic [ADDR_W-1:0]     cur_addr;
    logic [15:0]           remaining;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  full, empty, accept, push, pop;

    assign full   = (count == FULL_LVL);
    assign empty  = (count == '0);
    assign accept = (state == IDLE) && start && (length != 16'd0);
    assign push   = (state == WAIT) && rom_ready && !abort;
    assign pop    = out_pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept) state_nxt = ISSUE;
            ISSUE: if (rom_ready && !full) state_nxt = GUARD;
            GUARD: state_nxt = WAIT;
            WAIT: begin
                if (rom_ready)
                    state_nxt = (remaining == 16'd1) ? IDLE : ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_comb begin
        busy     = (state != IDLE);
        rom_load = (state == ISSUE) && rom_ready && !full && !abort;
    end

    // rom_addr follows cur_addr, so it only moves on run start and after pushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr  <= '0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!abort) begin
                if (accept) begin
                    cur_addr  <= base_addr;
                    remaining <= length;
                end else if (push) begin
                    cur_addr  <= cur_addr + 1'b1;
                    remaining <= remaining - 16'd1;
                    done      <= (remaining == 16'd1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rom_data;
    end

    assign rom_addr  = cur_addr;
    assign level     = count;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_rom_prefetch_fifo.sv
// Randomized scoreboard bench for rom_prefetch_fifo with a flash controller model.
// Expected load addresses and words come from the run rules, not from the DUT.
module tb_rom_prefetch_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] base_addr;
    logic [15:0] length;
    logic        abort;
    logic        busy;
    logic        done;
    logic [23:0] rom_addr;
    logic        rom_load;
    logic [7:0]  rom_data;
    logic        rom_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_pop;
    logic [4:0]  level;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int load_cnt = 0;

    logic [23:0] exp_addr [$];
    logic [7:0]  exp_data [$];

    rom_prefetch_fifo dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .length(length), .abort(abort), .busy(busy), .done(done),
        .rom_addr(rom_addr), .rom_load(rom_load), .rom_data(rom_data),
        .rom_ready(rom_ready), .out_data(out_data), .out_valid(out_valid),
        .out_pop(out_pop), .level(level)
    );

    always #5 clk = ~clk;

    // Flash controller: ready stays high one cycle after load (stale data),
    // then drops for a random latency, then returns addr[7:0].
    logic        guard_hi;
    logic        in_flight;
    logic [23:0] raddr;
    int          rcnt;
    logic        completing;

    assign completing = in_flight && !guard_hi && (rcnt == 0);
    assign rom_ready  = guard_hi || (rcnt == 0);
    assign rom_data   = completing ? raddr[7:0] : ~raddr[7:0];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            guard_hi  <= 1'b0;
            in_flight <= 1'b0;
            raddr     <= '0;
            rcnt      <= 0;
        end else begin
            guard_hi <= rom_load;
            if (rom_load) begin
                in_flight <= 1'b1;
                raddr     <= rom_addr;
                rcnt      <= int'($urandom_range(1, 4));
            end else if (!guard_hi && rcnt > 0) begin
                rcnt <= rcnt - 1;
            end else if (completing) begin
                in_flight <= 1'b0;
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [23:0] mon_a;
    logic [7:0]  mon_d;

    always @(negedge clk) begin
        if (!rst) begin
            if (rom_load) begin
                load_cnt++;
                check("load_needs_ready", 32'(rom_ready), 32'd1);
                if (exp_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_load: got %0h expected none", rom_addr);
                end else begin
                    mon_a = exp_addr.pop_front();
                    check("load_addr", 32'(rom_addr), 32'(mon_a));
                end
            end
            if (out_pop && out_valid) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", out_data);
                end else begin
                    mon_d = exp_data.pop_front();
                    check("pop_data", 32'(out_data), 32'(mon_d));
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(logic [23:0] b, logic [15:0] n, bit expect_run);
        logic [23:0] a;
        start     = 1'b1;
        base_addr = b;
        length    = n;
        if (expect_run) begin
            for (int i = 0; i < int'(n); i++) begin
                a = b + 24'(i);
                exp_addr.push_back(a);
                exp_data.push_back(a[7:0]);
            end
        end
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(int pct, int budget);
        int n = 0;
        while (busy && n < budget) begin
            out_pop = ($urandom_range(0, 99) < pct);
            step();
            n++;
        end
        out_pop = 1'b0;
        check("run_finishes", 32'(busy), 32'd0);
        step();
    endtask

    task automatic drain();
        int n = 0;
        while (out_valid && n < 100) begin
            out_pop = 1'b1;
            step();
            n++;
        end
        out_pop = 1'b0;
        check("drained", 32'(out_valid), 32'd0);
    endtask

    int d0, l0, n;

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        abort = 1'b0; out_pop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_load", 32'(rom_load), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        rst = 1'b0;
        step();

        d0 = done_cnt; l0 = load_cnt;
        do_start(24'h000100, 16'd3, 1'b1);
        check("start_busy", 32'(busy), 32'd1);
        wait_idle(0, 200);
        check("basic_done", 32'(done_cnt - d0), 32'd1);
        check("basic_loads", 32'(load_cnt - l0), 32'd3);
        check("basic_level", 32'(level), 32'd3);
        check("basic_head", 32'(out_data), 32'h00);
        drain();

        l0 = load_cnt;
        do_start(24'h002000, 16'd20, 1'b1);
        n = 0;
        while (level != 5'd16 && n < 400) begin step(); n++; end
        repeat (30) step();
        check("bp_level", 32'(level), 32'd16);
        check("bp_loads", 32'(load_cnt - l0), 32'd16);
        check("bp_busy", 32'(busy), 32'd1);
        out_pop = 1'b1;
        step();
        out_pop = 1'b0;
        repeat (30) step();
        check("bp_one_more", 32'(load_cnt - l0), 32'd17);
        check("bp_refill", 32'(level), 32'd16);
        wait_idle(50, 1000);
        drain();

        do_start(24'h000300, 16'd10, 1'b1);
        n = 0;
        while (!(level == 5'd5 && completing) && n < 400) begin step(); n++; end
        check("pp_reached", 32'(level == 5'd5 && completing), 32'd1);
        out_pop = 1'b1;
        step();
        out_pop = 1'b0;
        check("pp_level", 32'(level), 32'd5);
        wait_idle(50, 600);
        drain();

        d0 = done_cnt;
        do_start(24'hFFFFFE, 16'd4, 1'b1);
        wait_idle(30, 400);
        check("wrap_done", 32'(done_cnt - d0), 32'd1);
        drain();

        do_start(24'h000500, 16'd10, 1'b1);
        n = 0;
        while (!(level == 5'd3 && in_flight && !guard_hi && rcnt > 0) && n < 400) begin
            step(); n++;
        end
        check("ab_reached", 32'(level), 32'd3);
        abort = 1'b1;
        exp_addr.delete();
        exp_data.delete();
        d0 = done_cnt;
        step();
        abort = 1'b0;
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_level", 32'(level), 32'd0);
        check("ab_valid", 32'(out_valid), 32'd0);
        check("ab_data", 32'(out_data), 32'd0);
        do_start(24'h000600, 16'd2, 1'b1);
        wait_idle(0, 400);
        check("ab_new_done", 32'(done_cnt - d0), 32'd1);
        check("ab_late_dropped", 32'(level), 32'd2);
        drain();

        l0 = load_cnt;
        do_start(24'h000700, 16'd0, 1'b0);
        check("len0_busy", 32'(busy), 32'd0);
        repeat (10) step();
        check("len0_loads", 32'(load_cnt - l0), 32'd0);

        d0 = done_cnt;
        do_start(24'h000040, 16'd3, 1'b1);
        step();
        do_start(24'h000080, 16'd5, 1'b0);
        wait_idle(0, 300);
        check("busy_start_done", 32'(done_cnt - d0), 32'd1);
        check("busy_start_level", 32'(level), 32'd3);
        drain();

        out_pop = 1'b1;
        repeat (3) step();
        out_pop = 1'b0;
        check("empty_pop_level", 32'(level), 32'd0);
        check("empty_pop_valid", 32'(out_valid), 32'd0);
        do_start(24'h000010, 16'd2, 1'b1);
        wait_idle(0, 200);
        drain();

        check("addr_q_empty", 32'(exp_addr.size()), 32'd0);
        check("data_q_empty", 32'(exp_data.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rom_prefetch_fifo.md
# rom_prefetch_fifo

Streams a contiguous run of StrataFlash bytes from the ROM controller into a small first-word-fall-through FIFO, so a consumer (sound path or DMA engine) pops data without waiting on flash latency. It sits between the romController `load/ready/data` handshake and the consumer. Only one ROM read is in flight at a time. A read is issued only when the FIFO has guaranteed room.

## Interface
- `WIDTH`, 8, ROM data width (matches `SF_D_WIDTH`)
- `ADDR_W`, 24, ROM address width
- `DEPTH_LOG2`, 4, FIFO depth = 2^DEPTH_LOG2 entries
- `clk` in 1: system clock; single clock domain
- `rst` in 1: reset, asynchronous, active-high
- `start` in 1: one-cycle request; latches `base_addr` and `length`
- `base_addr` in ADDR_W: first ROM address of the run
- `length` in 16: number of words to fetch; 0 = no-op
- `abort` in 1: cancel run and flush FIFO
- `busy` out 1: run in progress
- `done` out 1: one-cycle pulse when the last word of a run is pushed
- `rom_addr` out ADDR_W: address to romController
- `rom_load` out 1: one-cycle read request to romController
- `rom_data` in WIDTH: read data from romController
- `rom_ready` in 1: romController idle / data valid
- `out_data` out WIDTH: FIFO head word
- `out_valid` out 1: FIFO non-empty
- `out_pop` in 1: consume the head word
- `level` out DEPTH_LOG2+1: FIFO occupancy, 0..2^DEPTH_LOG2

## Operation
- FSM states are IDLE, ISSUE, GUARD and WAIT.
- **IDLE**
  - `busy=0`.
  - `start=1` with `length!=0`: latch `cur_addr=base_addr` and `remaining=length`, go to ISSUE.
  - `start` with `length=0` is ignored; no `done` pulse.
- **ISSUE**
  - Requires `rom_ready=1` and `level + pending_pop_adjust < 2^DEPTH_LOG2`, i.e. `level` sampled this cycle is below full.
  - When both hold: drive `rom_load=1` for this cycle with `rom_addr=cur_addr`, go to GUARD.
  - Otherwise stay in ISSUE with `rom_load=0`.
- **GUARD**: a single cycle in which `rom_ready` is ignored. This covers the controller dropping `ready` one cycle after `load`. Go to WAIT.
- **WAIT**
  - On the first cycle with `rom_ready=1`: push `rom_data`, `cur_addr+=1`, `remaining-=1`.
  - If `remaining` becomes 0: pulse `done`, go to IDLE. Otherwise go to ISSUE.
- `cur_addr` wraps modulo 2^ADDR_W (0xFFFFFF+1 -> 0x000000).
- `start` while `busy=1` is ignored; the run in progress is unaffected.
- `abort` has priority over `start` and over the FSM.
  - Next state is IDLE; the FIFO is flushed (`level=0`, `out_valid=0`).
  - An in-flight read is discarded and never pushed; no `done` pulse.
  - The next run's ISSUE waits on `rom_ready=1`, so the abandoned flash access completes harmlessly.
- **FIFO**
  - Circular buffer with read/write pointers and a DEPTH_LOG2+1-bit count.
  - Pop happens when `out_pop & out_valid`. `out_pop` on empty is ignored.
  - Push and pop in the same cycle: `level` is unchanged, and both pointers advance.
  - Overflow is impossible: room is checked at ISSUE, there is only one read in flight, and pops only reduce occupancy.
  - `out_data` is the head entry when `out_valid=1`, and is forced to 0 when empty.
  - First-word-fall-through: the head is visible without a pop.

## Timing
- **Reset values:** `busy=0`, `done=0`, `rom_load=0`, `rom_addr=0`, `out_valid=0`, `out_data=0`, `level=0`, FSM=IDLE, pointers=0.
- **Start to first load:** `start` sampled at edge N gives `busy=1` after N. The earliest `rom_load=1` is cycle N+1 (the ISSUE cycle).
- **Load to push:** `rom_load` in cycle L, then GUARD in L+1, then the push happens at the end of the first cycle ≥ L+2 with `rom_ready=1`.
- **Push to output:** `out_valid` and `level` update the cycle after the push edge. `done` is high in that same cycle.
- **Throughput:** one word per (ROM latency + 2) cycles. With a 2-cycle ROM latency this is 4 cycles per word.
- **Pop:** `out_pop` sampled at edge P. The new head or `out_valid` update is visible after P.
- **Abort:** takes effect at the first edge where it is sampled. `busy=0` the following cycle.
- `rom_addr` holds its last value outside ISSUE. It changes only on ISSUE entry and after pushes.

## Test plan
- **Basic run:** reset; `base_addr=0x000100`, `length=3`, ROM model returns addr[7:0] after 2 cycles. Required: 3 `rom_load` pulses at 0x100, 0x101 and 0x102; FIFO holds 0x00, 0x01, 0x02; `done` pulses once; `busy` is 0 afterwards.
- **Full back-pressure:** `length=20`, DEPTH=16, no pops. Required: `level` stops at 16 and `rom_load` stays 0. Then pop one word; required: exactly one more load, `level` returns to 16.
- **Simultaneous push/pop:** `out_pop` held high during a push cycle at `level=5`. Required: `level` stays 5 and data order is preserved.
- **Wrap-around:** `base_addr=0xFFFFFE`, `length=4`. Required: loads at 0xFFFFFE, 0xFFFFFF, 0x000000 and 0x000001.
- **Abort mid-read:** abort during WAIT with 3 words queued. Required:
  - `level=0`, `out_valid=0`, no `done`.
  - The late `rom_ready` data is not pushed.
  - A new `start` issues its first load only after `rom_ready=1`.
- **Ignored requests:**
  - `start` with `length=0`: required `busy` stays 0.
  - `start` while `busy`: required the original run completes unchanged.
  - `out_pop` on empty: required no pointer change.
